decoder_seq: RTL and testbench
==============================

// Module: decoder_seq
// PURPOSE
//   Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder; generalises the
//   fixed 3-to-8 enable decoder. Two modes:
//   - DIRECT: decodes a handshaked select code and holds it for a programmable dwell.
//   - SCAN: auto-walks the one-hot output across all lines.
//   Drives chip-select / row-select / LED-scan lines in the peripheral layer.
// PARAMETERS
//   SEL_W    3   select code width; output width N = 2**SEL_W
//   DWELL_W  4   dwell count width; each slot lasts dwell+1 cycles
// PORTS
//   clk         in   1        system clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   en          in   1        global enable; low = synchronous abort
//   scan_en     in   1        request SCAN mode
//   sel_valid   in   1        select code valid (DIRECT)
//   sel_ready   out  1        = en & ~scan_en & (state==IDLE), combinational
//   sel         in   SEL_W    select code
//   dwell       in   DWELL_W  slot length minus one; sampled at each slot start
//   dout        out  N        registered one-hot output, all-zero when idle
//   dout_valid  out  1        high whenever dout is non-zero
//   wrap        out  1        1-cycle pulse when SCAN index wraps N-1 -> 0
//   busy        out  1        state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - dout=0, dout_valid=0, wrap=0, busy=0
//     - state=IDLE, idx=0, dwell counter=0
//   States: IDLE, DRIVE, SCAN. All outputs are registered except sel_ready.
//   IDLE:
//     - en & scan_en -> SCAN: idx=0, load dwell; dout=1 on the next edge.
//     - else sel_valid & sel_ready -> DRIVE: dout = 1<<sel on the next edge
//       (1-cycle latency); load dwell.
//     - scan_en and sel_valid together: SCAN wins; sel is not accepted
//       (sel_ready=0).
//   DRIVE:
//     - dout held for dwell+1 cycles. Then dout=0 and state=IDLE; sel_ready
//       rises in the first cycle dout=0.
//     - No back-to-back accept: there is at least one idle cycle between
//       DRIVE slots.
//   SCAN:
//     - Each idx is held for dwell+1 cycles; then idx=idx+1 mod N and dwell
//       is re-sampled.
//     - On the N-1 -> 0 step, wrap=1 in the same cycle that dout returns to bit 0.
//     - scan_en low: the current slot completes, then dout=0 and state=IDLE.
//       There is no partial slot.
//   en=0 in any state:
//     - Next edge: dout=0, state=IDLE, counters cleared, wrap=0.
//     - sel_ready=0 while en=0.
//   dwell=0 gives a 1-cycle slot. The dwell counter saturates and does not wrap.
//   dout always has at most one bit set, in every state and on every transition.
//   Reset mid-operation clears immediately, with no completion of the slot.
// CONFIGURATION
//   DECODER_PARITY_EN defined:
//     - Adds ports sel_par (in, 1) and par_err (out, 1, registered, reset 0).
//     - On a DIRECT accept, ^{sel,sel_par} must be 0 (even parity).
//     - On a mismatch: the transfer is consumed, dout stays 0, the state stays
//       IDLE, and par_err pulses for 1 cycle.
//     - SCAN mode is unaffected.
//   DECODER_PARITY_EN undefined: the ports are absent and no check is made.
// TESTING (SEL_W=3, DWELL_W=4)
//   1. en=1, sel=5, sel_valid=1, dwell=2 for 1 cycle
//      -> next cycle dout=8'h20 for 3 cycles, then 8'h00; sel_ready=1.
//   2. scan_en=1, dwell=0
//      -> dout 01,02,04,...,80,01 one per cycle; wrap=1 only on the 80->01 cycle.
//   3. scan_en=1 and sel_valid=1 with sel=2 in the same cycle
//      -> SCAN starts at 8'h01; sel not accepted.
//   4. DRIVE sel=7, dwell=9; en=0 on the 3rd cycle
//      -> dout=0 next edge; busy=0.
//   5. rst_n=0 mid-SCAN at idx=4
//      -> dout=0, wrap=0 immediately; after release the state is IDLE with idx=0.
//   6. [DECODER_PARITY_EN] sel=3, sel_par=1
//      -> par_err pulse, dout=0; with sel_par=0 -> dout=8'h08.

Source files
------------

// File: rtl/decoder_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with DIRECT (handshaked, dwell-held) and SCAN modes.
// Optional select-parity check is compiled in with `define DECODER_PARITY_EN.
module decoder_seq #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  scan_en,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   dout,
  output logic                  dout_valid,
  output logic                  wrap,
  output logic                  busy
`ifdef DECODER_PARITY_EN
  ,
  input  logic                  sel_par,
  output logic                  par_err
`endif
);

  localparam int N = 2**SEL_W;

  typedef enum logic [1:0] {IDLE, DRIVE, SCAN} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]         dout_q, dout_d;
  logic                 dval_q, dval_d;
  logic                 wrap_q, wrap_d;
  logic                 perr_q, perr_d;
  logic                 par_bad;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

  // Remaining-cycle counter never wraps below zero.
  function automatic logic [DWELL_W-1:0] cnt_step(input logic [DWELL_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

`ifdef DECODER_PARITY_EN
  assign par_bad = ^{sel, sel_par};
  assign par_err = perr_q;
`else
  assign par_bad = 1'b0;
`endif

  assign sel_ready  = en & ~scan_en & (state_q == IDLE);
  assign dout       = dout_q;
  assign dout_valid = dval_q;
  assign wrap       = wrap_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    wrap_d  = 1'b0;
    perr_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      dout_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (scan_en) begin
            state_d = SCAN;
            idx_d   = '0;
            cnt_d   = dwell;
            dout_d  = onehot('0);
          end else if (sel_valid && sel_ready) begin
            // A parity failure consumes the transfer without driving a line.
            if (par_bad) begin
              perr_d = 1'b1;
            end else begin
              state_d = DRIVE;
              idx_d   = sel;
              cnt_d   = dwell;
              dout_d  = onehot(sel);
            end
          end
        end
        DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_step(cnt_q);
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            dout_d  = '0;
          end
        end
        SCAN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_step(cnt_q);
          end else if (!scan_en) begin
            state_d = IDLE;
            idx_d   = '0;
            dout_d  = '0;
          end else begin
            idx_d  = idx_q + 1'b1;
            cnt_d  = dwell;
            dout_d = onehot(idx_d);
            wrap_d = &idx_q;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          dout_d  = '0;
        end
      endcase
    end
    dval_d = |dout_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      wrap_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      wrap_q  <= wrap_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench for decoder_seq: directed vector table, hand-written corner
// sequences and randomized stimulus against a slot-level behavioural model.
module tb_decoder_seq;
  localparam int SEL_W   = 3;
  localparam int DWELL_W = 4;
  localparam int N       = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en, scan_en, sel_valid, sel_ready;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       dout;
  logic               dout_valid, wrap, busy;
  logic               sel_par;
  logic               par_err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  decoder_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .scan_en(scan_en),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel(sel), .dwell(dwell),
    .dout(dout), .dout_valid(dout_valid), .wrap(wrap), .busy(busy)
`ifdef DECODER_PARITY_EN
    , .sel_par(sel_par), .par_err(par_err)
`endif
  );

`ifndef DECODER_PARITY_EN
  assign par_err = 1'b0;
`endif

  // Slot-level model: mode 0 idle, 1 direct, 2 scan; m_left = further cycles of current slot.
  int         m_mode, m_line, m_left;
  logic [7:0] m_dout;
  bit         m_wrap, m_perr;

  function automatic void model_reset();
    m_mode = 0; m_line = 0; m_left = 0; m_dout = 8'h00; m_wrap = 0; m_perr = 0;
  endfunction

  function automatic void model_edge();
    bit bad;
    bad = 0;
`ifdef DECODER_PARITY_EN
    bad = ($countones({sel, sel_par}) % 2) != 0;
`endif
    m_wrap = 0;
    m_perr = 0;
    if (!en) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (scan_en) begin
             m_mode = 2; m_line = 0; m_left = int'(dwell);
           end else if (sel_valid) begin
             if (bad) m_perr = 1;
             else begin m_mode = 1; m_line = int'(sel); m_left = int'(dwell); end
           end
        1: if (m_left > 0) m_left--; else m_mode = 0;
        default: if (m_left > 0) m_left--;
                 else if (!scan_en) m_mode = 0;
                 else begin
                   m_line = (m_line + 1) % N;
                   m_wrap = (m_line == 0);
                   m_left = int'(dwell);
                 end
      endcase
    end
    m_dout = (m_mode == 0) ? 8'h00 : 8'(1 << m_line);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle, then check the combinational ready against the model.
  task automatic drive(input bit e, input bit s, input bit v, input int sl, input int dw);
    en = e; scan_en = s; sel_valid = v; sel = sl[SEL_W-1:0]; dwell = dw[DWELL_W-1:0];
    sel_par = ^sel;
    #1;
    check("sel_ready", 32'(sel_ready), 32'(e && !s && m_mode == 0));
  endtask

  task automatic step(input bit chk);
    @(posedge clk);
    model_edge();
    #1;
    if (chk) begin
      check("dout", 32'(dout), 32'(m_dout));
      check("dout_valid", 32'(dout_valid), 32'(m_dout != 0));
      check("wrap", 32'(wrap), 32'(m_wrap));
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("onehot", 32'($countones(dout) <= 1), 32'd1);
`ifdef DECODER_PARITY_EN
      check("par_err", 32'(par_err), 32'(m_perr));
`endif
    end
  endtask

  typedef struct {
    bit e, s, v; int sl, dw;
    bit rdy; logic [7:0] d; bit w, b;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit e, bit s, bit v, int sl, int dw,
                              bit rdy, logic [7:0] d, bit w, bit b);
    vec_t t;
    t.e = e; t.s = s; t.v = v; t.sl = sl; t.dw = dw; t.rdy = rdy; t.d = d; t.w = w; t.b = b;
    tbl.push_back(t);
  endfunction

  initial begin
    int on_cnt;
    rst_n = 1'b0; en = 0; scan_en = 0; sel_valid = 0; sel = '0; dwell = '0; sel_par = 0;
    model_reset();
    #12;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_dval", 32'(dout_valid), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // DIRECT sel=5 dwell=2, no back-to-back accept, then SCAN sequences.
    add(1,0,1,5,2, 1,8'h20,0,1);
    add(1,0,0,0,2, 0,8'h20,0,1);
    add(1,0,0,0,2, 0,8'h20,0,1);
    add(1,0,0,0,2, 0,8'h00,0,0);
    add(1,0,1,1,0, 1,8'h02,0,1);
    add(1,0,1,6,0, 0,8'h00,0,0);
    add(1,0,1,6,0, 1,8'h40,0,1);
    add(1,0,0,0,0, 0,8'h00,0,0);
    add(1,1,1,2,0, 0,8'h01,0,1);
    for (int i = 1; i < 8; i++) add(1,1,0,0,0, 0,8'(1 << i),0,1);
    add(1,1,0,0,0, 0,8'h01,1,1);
    add(1,1,0,0,0, 0,8'h02,0,1);
    add(1,0,0,0,0, 0,8'h00,0,0);
    add(1,0,0,0,0, 1,8'h00,0,0);
    add(1,1,0,0,1, 0,8'h01,0,1);
    add(1,0,0,0,1, 0,8'h01,0,1);
    add(1,0,0,0,1, 0,8'h00,0,0);
    add(1,1,0,0,0, 0,8'h01,0,1);
    add(1,1,0,0,2, 0,8'h02,0,1);
    add(1,1,0,0,0, 0,8'h02,0,1);
    add(1,1,0,0,0, 0,8'h02,0,1);
    add(1,1,0,0,0, 0,8'h04,0,1);
    add(1,0,0,0,0, 0,8'h00,0,0);

    foreach (tbl[i]) begin
      en = tbl[i].e; scan_en = tbl[i].s; sel_valid = tbl[i].v;
      sel = tbl[i].sl[SEL_W-1:0]; dwell = tbl[i].dw[DWELL_W-1:0]; sel_par = ^sel;
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(sel_ready), 32'(tbl[i].rdy));
      step(0);
      check($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].d));
      check($sformatf("tbl%0d_wrap", i), 32'(wrap), 32'(tbl[i].w));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
    end

    // en dropped on the third cycle of a long DIRECT slot.
    drive(1,0,1,7,9); step(1);
    check("t4_first", 32'(dout), 32'h80);
    drive(1,0,0,0,9); step(1); step(1);
    drive(0,0,0,0,9); step(1);
    check("t4_abort_dout", 32'(dout), 32'h0);
    check("t4_abort_busy", 32'(busy), 32'h0);
    drive(1,0,0,0,0); step(1);

    // Maximum dwell holds the line for 16 cycles.
    drive(1,0,1,4,15); step(1);
    on_cnt = (dout == 8'h10) ? 1 : 0;
    drive(1,0,0,0,0);
    for (int i = 0; i < 18; i++) begin
      step(1);
      if (dout == 8'h10) on_cnt++;
    end
    check("dwell15_len", 32'(on_cnt), 32'd16);

    // Asynchronous reset in the middle of a scan at idx=4.
    drive(1,1,0,0,0);
    for (int i = 0; i < 5; i++) step(1);
    check("t5_pre", 32'(dout), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("t5_dout", 32'(dout), 32'h0);
    check("t5_wrap", 32'(wrap), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    model_reset();
    drive(1,0,0,0,0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    drive(1,1,0,0,0); step(1);
    check("t5_restart", 32'(dout), 32'h01);
    drive(1,0,0,0,0); step(1); step(1);

`ifdef DECODER_PARITY_EN
    drive(1,0,1,3,0); sel_par = 1'b1; step(1);
    check("t6_perr", 32'(par_err), 32'h1);
    check("t6_dout", 32'(dout), 32'h0);
    drive(1,0,0,0,0); step(1);
    check("t6_perr_clr", 32'(par_err), 32'h0);
    drive(1,0,1,3,0); sel_par = 1'b0; step(1);
    check("t6_accept", 32'(dout), 32'h08);
    drive(1,0,0,0,0); step(1);
`endif

    // Randomized traffic against the model.
    scan_en = 0;
    for (int i = 0; i < 800; i++) begin
      bit e, s, v;
      int dw;
      e  = ($urandom_range(0, 19) != 0);
      s  = ($urandom_range(0, 9) == 0) ? !scan_en : scan_en;
      v  = $urandom_range(0, 1) != 0;
      dw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      drive(e, s, v, int'($urandom_range(0, 7)), dw);
      if ($urandom_range(0, 7) == 0) sel_par = ~sel_par;
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
